// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ sources, with bounded burst lock.
// Accept in cycle n drives RFWE/RFWA/RFWD in n+1; REQ_READY is combinational and one-hot, forced low during RST.
module rf_write_arbiter #(
    parameter int NREQ         = 3,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 4,
    parameter int ZERO_PROTECT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_VALID,
    input  logic [NREQ-1:0]      REQ_LOCK,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*DW-1:0]   REQ_DATA,
    output logic [NREQ-1:0]      REQ_READY,
    output logic [1:0]           RFWE,
    output logic [AW-1:0]        RFWA,
    output logic [DW-1:0]        RFWD,
    output logic [1:0]           GRANT_ID,
    output logic                 ZERO_DROP
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    owner, owner_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [1:0]    gsel;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    function automatic logic [1:0] wrap_inc(input logic [1:0] x);
        if (int'(x) >= NREQ - 1) return 2'd0;
        return x + 2'd1;
    endfunction

    // Scan from the farthest candidate back to ptr so the last hit is the first in round-robin order.
    always_comb begin
        int j;
        j         = 0;
        gsel      = '0;
        accept    = 1'b0;
        REQ_READY = '0;
        if (!RST) begin
            if (state == LOCKED) begin
                gsel = owner;
                if (REQ_VALID[owner]) accept = 1'b1;
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    j = (int'(ptr) + k) % NREQ;
                    if (REQ_VALID[j]) begin
                        gsel   = 2'(j);
                        accept = 1'b1;
                    end
                end
            end
            if (accept) REQ_READY[gsel] = 1'b1;
        end
    end

    assign sel_addr = REQ_ADDR[int'(gsel)*AW +: AW];
    assign sel_data = REQ_DATA[int'(gsel)*DW +: DW];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (REQ_LOCK[gsel] && MAX_BURST > 1) begin
                        state_nxt = LOCKED;
                        owner_nxt = gsel;
                        bcnt_nxt  = BW'(1);
                    end else begin
                        ptr_nxt = wrap_inc(gsel);
                    end
                end
            end
            LOCKED: begin
                // An idle owner releases immediately so the others never wait on a stalled burst.
                if (accept && REQ_LOCK[owner] && (int'(bcnt) + 1 < MAX_BURST)) begin
                    bcnt_nxt = bcnt + BW'(1);
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_inc(owner);
                    bcnt_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RFWE      <= 2'b00;
            RFWA      <= '0;
            RFWD      <= '0;
            GRANT_ID  <= '0;
            ZERO_DROP <= 1'b0;
        end else if (accept) begin
            RFWA     <= sel_addr;
            RFWD     <= sel_data;
            GRANT_ID <= gsel;
            // Address 0 is hard-wired in the register file: consume the beat, suppress the write.
            if (ZERO_PROTECT != 0 && sel_addr == '0) begin
                RFWE      <= 2'b00;
                ZERO_DROP <= 1'b1;
            end else begin
                RFWE      <= 2'b01;
                ZERO_DROP <= 1'b0;
            end
        end else begin
            RFWE      <= 2'b00;
            ZERO_DROP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_rf_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MB   = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   REQ_VALID = '0;
    logic [NREQ-1:0]   REQ_LOCK  = '0;
    logic [NREQ*AW-1:0] REQ_ADDR = '0;
    logic [NREQ*DW-1:0] REQ_DATA = '0;

    logic [NREQ-1:0] rdy_a, rdy_b;
    logic [1:0]      we_a, we_b, gid_a, gid_b;
    logic [AW-1:0]   wa_a, wa_b;
    logic [DW-1:0]   wd_a, wd_b;
    logic            zd_a, zd_b;

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB), .ZERO_PROTECT(1)) u_dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LOCK(REQ_LOCK),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_READY(rdy_a),
        .RFWE(we_a), .RFWA(wa_a), .RFWD(wd_a), .GRANT_ID(gid_a), .ZERO_DROP(zd_a));

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB), .ZERO_PROTECT(0)) u_dut_zp0 (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LOCK(REQ_LOCK),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_READY(rdy_b),
        .RFWE(we_b), .RFWA(wa_b), .RFWD(wd_b), .GRANT_ID(gid_b), .ZERO_DROP(zd_b));

    always #5 CLK = ~CLK;

    typedef struct {
        bit            rst;
        bit            acc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            g;
    } exp_t;

    exp_t expq[$];
    int   obs_g[$];
    int   tests = 0;
    int   fails = 0;

    // Pending beats per requester and the beat currently presented.
    int            cnt[NREQ];
    bit            lk[NREQ];
    logic [AW-1:0] ad[NREQ];
    logic [DW-1:0] da[NREQ];
    bit            rnd_mode = 1'b0;

    bit m_locked = 1'b0;
    int m_ptr = 0, m_owner = 0, m_bcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int any_pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += cnt[i];
        return s;
    endfunction

    task automatic model_step();
        int g;
        exp_t e;
        logic [NREQ-1:0] er;
        g  = -1;
        er = '0;
        e  = '{rst: 1'b0, acc: 1'b0, a: '0, d: '0, g: 0};
        if (RST) begin
            m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_bcnt = 0;
            e.rst = 1'b1;
        end else begin
            if (m_locked) begin
                if (cnt[m_owner] > 0) g = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (g < 0 && cnt[i] > 0) g = i;
                end
            end
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", rdy_a, er);
        chk("req_ready_zp0", rdy_b, er);
        if (!RST) begin
            if (g >= 0) begin
                e.acc = 1'b1; e.a = ad[g]; e.d = da[g]; e.g = g;
                if (!m_locked) begin
                    if (lk[g] && MB > 1) begin
                        m_locked = 1'b1; m_owner = g; m_bcnt = 1;
                    end else begin
                        m_ptr = (g + 1) % NREQ;
                    end
                end else begin
                    m_bcnt++;
                    if (!lk[g] || m_bcnt == MB) begin
                        m_locked = 1'b0;
                        m_ptr = (m_owner + 1) % NREQ;
                    end
                end
                cnt[g]--;
                if (rnd_mode) begin
                    ad[g] = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
                    da[g] = $urandom;
                    lk[g] = 1'($urandom_range(0, 1));
                end else begin
                    da[g] = da[g] + 1;
                end
            end else if (m_locked) begin
                m_locked = 1'b0;
                m_ptr = (m_owner + 1) % NREQ;
            end
        end
        expq.push_back(e);
    endtask

    task automatic step(input bit rst);
        @(negedge CLK);
        RST = rst;
        for (int i = 0; i < NREQ; i++) begin
            REQ_VALID[i] = (cnt[i] > 0);
            REQ_LOCK[i]  = lk[i];
            REQ_ADDR[i*AW +: AW] = ad[i];
            REQ_DATA[i*DW +: DW] = da[i];
        end
        #1;
        model_step();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0; lk[i] = 1'b0; ad[i] = AW'(i + 1); da[i] = 32'h100 * (i + 1);
        end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        obs_g.delete();
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while (any_pending() > 0 && n < max) begin
            step(1'b0);
            n++;
        end
        chk("drain", any_pending(), 0);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic chk_seq(input string name, input int e[8], input int n);
        chk({name, "_len"}, obs_g.size(), n);
        for (int i = 0; i < n && i < obs_g.size(); i++) chk(name, obs_g[i], e[i]);
    endtask

    // Monitor: one expected entry per cycle, compared after the edge that registers it.
    initial begin
        exp_t e;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        int lg;
        logic [1:0] xwe, xwe0;
        logic xzd;
        la = '0; ld = '0; lg = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.rst) begin
                    la = '0; ld = '0; lg = 0;
                    xwe = 2'b00; xwe0 = 2'b00; xzd = 1'b0;
                end else if (e.acc) begin
                    la = e.a; ld = e.d; lg = e.g;
                    xzd  = (e.a == '0);
                    xwe  = xzd ? 2'b00 : 2'b01;
                    xwe0 = 2'b01;
                end else begin
                    xwe = 2'b00; xwe0 = 2'b00; xzd = 1'b0;
                end
                chk("rfwe", we_a, xwe);
                chk("zero_drop", zd_a, xzd);
                chk("rfwa", wa_a, la);
                chk("rfwd", wd_a, ld);
                chk("grant_id", gid_a, lg);
                chk("rfwe_zp0", we_b, xwe0);
                chk("zero_drop_zp0", zd_b, 1'b0);
                chk("rfwa_zp0", wa_b, la);
                chk("rfwd_zp0", wd_b, ld);
                if (we_a == 2'b01 || zd_a) obs_g.push_back(int'(gid_a));
            end
        end
    end

    initial begin
        // Plain round-robin with all three requesters valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 2;
        run_until_idle(40);
        chk_seq("rr_order", '{0, 1, 2, 0, 1, 2, 0, 0}, 6);

        // Requester 1 burst-locks while 0 and 2 wait.
        do_reset();
        lk[1] = 1'b1; cnt[1] = 5; cnt[2] = 1;
        step(1'b0);
        cnt[0] = 1;
        run_until_idle(40);
        chk_seq("burst_lock", '{1, 1, 1, 1, 2, 0, 1, 0}, 7);

        // Requester 2 locks then goes idle: one release cycle, then requester 0.
        do_reset();
        lk[2] = 1'b1; cnt[2] = 2;
        step(1'b0);
        cnt[0] = 1;
        run_until_idle(40);
        chk_seq("lock_drop", '{2, 2, 0, 0, 0, 0, 0, 0}, 3);

        // Write to address 0 is consumed but dropped on the protected instance.
        do_reset();
        ad[0] = '0; da[0] = 32'hDEAD; cnt[0] = 1;
        run_until_idle(40);
        chk_seq("zero_addr", '{0, 0, 0, 0, 0, 0, 0, 0}, 1);

        // Reset in the third beat of a burst.
        do_reset();
        lk[1] = 1'b1; cnt[1] = 5; ad[1] = 5'd7;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        cnt[0] = 1;
        run_until_idle(40);
        chk_seq("rst_burst", '{1, 1, 0, 1, 1, 1, 0, 0}, 6);

        // Lone requester, then idle with held address/data.
        do_reset();
        cnt[2] = 3; ad[2] = 5'd9;
        run_until_idle(40);
        chk_seq("single_req", '{2, 2, 2, 0, 0, 0, 0, 0}, 3);

        // Randomized traffic with occasional resets.
        rnd_mode = 1'b1;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (cnt[i] == 0 && $urandom_range(0, 2) == 0) begin
                    cnt[i] = $urandom_range(1, 5);
                    lk[i]  = 1'($urandom_range(0, 1));
                    ad[i]  = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
                    da[i]  = $urandom;
                end
            end
            step($urandom_range(0, 99) == 0);
        end
        run_until_idle(200);
        @(posedge CLK);
        #3;
        chk("scoreboard_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter that shares the single register-file write port (RFWE/RFWA/RFWD) among NREQ writeback sources, such as the ALU result, the load path and the debug/initialisation port. Each source uses a valid/ready handshake. The arbiter registers the winning write into a one-beat output stage that drives the register file directly. A source may lock the port for a bounded burst of back-to-back writes.

## Interface
- NREQ, 3: number of requesters (2..4).
- AW, 5: register address width.
- DW, 32: data width.
- MAX_BURST, 4: maximum consecutive beats one locked owner may take (≥1).
- ZERO_PROTECT, 1: when 1, accepted writes to address 0 are consumed but not performed.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NREQ  per-requester write request.
- REQ_LOCK  in  NREQ  per-requester burst-lock request, qualified by REQ_VALID.
- REQ_ADDR  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- REQ_DATA  in  NREQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- REQ_READY  out  NREQ  one-hot grant; combinational from current state and REQ_VALID.
- RFWE  out  2  register-file write enable: 2'b01 = write, 2'b00 = no write.
- RFWA  out  AW  register-file write address.
- RFWD  out  DW  register-file write data.
- GRANT_ID  out  2  index of the requester whose beat is in the output stage.
- ZERO_DROP  out  1  one-cycle pulse: a beat to address 0 was dropped.

## Operation
- **Handshake**
  - A beat is accepted on a cycle where REQ_VALID[i] & REQ_READY[i] = 1.
  - A requester holds VALID, ADDR, DATA and LOCK stable until it is accepted.
  - REQ_READY is at most one-hot. It is never asserted without the matching VALID.
- **Round-robin arbitration**
  - Pointer PTR ranges 0..NREQ-1.
  - The grant goes to the first i with VALID=1, searching PTR, PTR+1, … with modulo-NREQ wrap.
  - After an accept from requester g in state IDLE, PTR ← (g+1) mod NREQ.
- **FSM states**
  - IDLE: normal round-robin arbitration.
  - LOCKED: OWNER holds the port; BCNT counts beats taken in the burst.
- **IDLE → LOCKED**
  - Taken when the accepted beat from g has REQ_LOCK[g]=1 and MAX_BURST>1.
  - Sets OWNER=g, BCNT=1.
- **Behaviour in LOCKED**
  - REQ_READY = VALID[OWNER] on the OWNER bit only; all other bits are 0.
  - Each accepted beat increments BCNT.
- **LOCKED → IDLE (release)** occurs on any of:
  - an accepted owner beat with LOCK=0;
  - an accepted beat that makes BCNT = MAX_BURST;
  - VALID[OWNER]=0 in any LOCKED cycle, with no beat accepted that cycle.
- **Pointer and fairness**
  - On release, PTR ← (OWNER+1) mod NREQ.
  - PTR is not changed inside LOCKED.
  - Every continuously valid requester is granted within (NREQ-1)*MAX_BURST+1 accepts.
- **Output stage** (registered, updated every cycle)
  - Beat accepted: RFWA ← addr, RFWD ← data, GRANT_ID ← g.
  - RFWE ← 2'b01, except 2'b00 when ZERO_PROTECT=1 and addr=0. In that case ZERO_DROP=1 for that cycle.
  - No accept: RFWE ← 2'b00, ZERO_DROP ← 0. RFWA, RFWD and GRANT_ID hold their values.
- **Data path**: no arithmetic is performed; data passes through unmodified at full DW width.

## Timing
- **Pipeline**
  - Accept in cycle n → RFWE/RFWA/RFWD valid in cycle n+1.
  - The register file captures the write at the end of n+1. Readers see the new value from cycle n+2.
- **Throughput**: one beat per cycle, with no bubble between consecutive grants, including a requester change.
- **Reset values**
  - State=IDLE, PTR=0, OWNER=0, BCNT=0.
  - RFWE=2'b00, RFWA=0, RFWD=0, GRANT_ID=0, ZERO_DROP=0.
  - REQ_READY follows IDLE arbitration with PTR=0.
- **RST mid-burst**
  - The lock is abandoned and no beat is accepted in the RST cycle (REQ_READY forced to 0 while RST=1).
  - A beat already in the output stage is cancelled: RFWE=0 in the cycle after RST.
- **Simultaneous requests**: grant follows strict PTR order. An unselected requester's inputs are ignored.
- **MAX_BURST=1**: LOCK is ignored and the FSM never enters LOCKED.

## Test plan
- Reset, then VALID=3'b111 held for 6 cycles with distinct addresses → grants 0,1,2,0,1,2; RFWE=2'b01 each cycle from cycle 2; RFWA/RFWD match the granted requester one cycle later.
- Requester 1 holds LOCK=1 with VALID=3'b111 → four consecutive grants to 1 (MAX_BURST=4), then 2, then 0; REQ_READY[0] and REQ_READY[2]=0 during the burst.
- Requester 2 locks, drops VALID after 2 beats → release in that cycle; next grant goes to 0 the following cycle; PTR=0.
- Requester 0 writes addr 0, data 32'hDEAD (ZERO_PROTECT=1) → handshake completes; next cycle RFWE=2'b00 and ZERO_DROP=1. Repeat with ZERO_PROTECT=0 → RFWE=2'b01, RFWA=0.
- RST asserted in the third beat of a locked burst → no accept that cycle; RFWE=0 next cycle; after release, first grant goes to requester 0.
- Single requester 2 valid for 3 cycles, then idle → three writes on consecutive cycles, then RFWE=0 with RFWA/RFWD holding the last values.
